rtc_poll_master: RTL and testbench
==================================

Name: rtc_poll_master

Overview:
- Bus initiator that drives the RTC peripheral's memory-mapped register interface (cs/wr/addr/wdata/rdata) from the master side.
- Issues the initial-value write on request.
- Periodically reads the three packed-decimal time words and splits each into binary fields with a sequential divide-by-100.
- Checks the three words for torn reads, then presents a coherent sec/min/hour/day/month snapshot with a valid pulse.

Parameters:
- POLL_DIV, 100000000: clk cycles between poll ticks; legal range ≥ 40.
- MAX_RETRY, 2: re-read attempts after a tear mismatch before giving up.
- BASE_ADDR, 32'h0: peripheral base; word offsets 0x0 (init), 0x4 (month_day), 0x8 (hour_min), 0xC (min_sec).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- poll_en  in  1  enables the periodic poll counter
- set_req  in  1  level request to write set_value; held until set_ack
- set_value  in  26  initial counter value
- set_ack  out  1  one-cycle pulse when the write has been issued
- bus_cs  out  1  peripheral select
- bus_wr  out  1  1 = write, 0 = read
- bus_addr  out  32  BASE_ADDR + offset
- bus_wdata  out  32  write data
- bus_rdata  in  32  combinational read data, valid in the same cycle as addr
- sec  out  6  seconds
- min  out  6  minutes
- hour  out  5  hours
- day  out  5  day
- month  out  4  month
- time_valid  out  1  one-cycle pulse when outputs are updated
- read_err  out  1  one-cycle pulse when retries are exhausted
- busy  out  1  FSM is not in IDLE

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE, poll counter 0, retry count 0, pending flag 0, divider aborted. All outputs 0.
- Bus timing: every access is one cycle with bus_cs=1.
  - Reads capture bus_rdata[13:0] at the end of that cycle.
  - bus_wr, bus_addr and bus_wdata are 0 whenever bus_cs=0.
- Poll counter: counts only while poll_en=1.
  - Reaching POLL_DIV-1 generates a tick and the counter wraps to 0.
  - poll_en=0 clears the counter and the pending flag.
  - A tick arriving while busy sets pending (one deep); further ticks are dropped.
- FSM states and transitions:
  - IDLE: set_req has priority over tick/pending. set_req → SET; else tick or pending → RD_MD (pending cleared).
  - SET: bus_cs=1, bus_wr=1, addr=BASE+0x0, wdata={6'b0,set_value}. set_ack pulses the next cycle. Return to IDLE.
  - RD_MD → RD_HM → RD_MS: one cycle each, addresses +0x4, +0x8, +0xC, capturing MD, HM and MS.
  - DIV_MS, DIV_HM, DIV_MD: start the divider on the word, wait for done, store quotient/remainder. Order is MS, HM, MD.
  - CHECK: compare HM remainder with MS quotient (both are minutes).
    - Equal: register sec=MS rem, min=MS quot, hour=HM quot, day=MD rem, month=MD quot (truncated to port widths). Pulse time_valid, clear retry, go to IDLE.
    - Unequal with retry<MAX_RETRY: retry++, go to RD_MD.
    - Unequal with retry=MAX_RETRY: pulse read_err, leave outputs unchanged, clear retry, go to IDLE.
- Latency: first RD_MD cycle = cycle 0; time_valid is high in cycle 28 (3 reads + 3×8 divider + CHECK + output register).
- set_req asserted mid-poll waits until IDLE; the poll is never aborted.
- Words above 9999 are not rejected; fields are truncated.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package: state encoding, register offset constants (OFS_INIT/MD/HM/MS), field widths, and the divider step count of 7.
- Sub-module dec100_split: 14-bit restoring divide by 100 using trial subtracts of 6400, 3200, 1600, 800, 400, 200, 100.
  - Ports: clk, reset, start, value[13:0] → quot[6:0], rem[6:0], done.
  - Timing: done pulses 7 cycles after start. A start while active restarts it. Reset aborts it.

Test Plan:
- Set: reset, then set_req=1, set_value=26'h123456 → exactly one cycle with cs=1, wr=1, addr=0x0, wdata=32'h00123456; set_ack the next cycle; busy=0 afterwards.
- Poll decode: POLL_DIV=40, poll_en=1, responder returns 1231 @0x4, 2359 @0x8, 5958 @0xC → time_valid 28 cycles after the first read with month=12, day=31, hour=23, min=59, sec=58.
- Tear with recovery: first pass HM=2359, MS=0000 (mismatch); second pass HM=0000, MS=0000 → one retry re-read of all three words, then time_valid with hour=0, min=0, sec=0.
- Tear exhausted: MAX_RETRY=2, persistent mismatch → 3 full read passes, read_err pulse, outputs hold their previous values, no time_valid.
- Arbitration: set_req and tick in the same IDLE cycle → SET first, then the poll from pending; a second tick during the poll is dropped (only one extra poll runs).
- Reset mid-operation: assert reset during DIV_HM → bus_cs=0 immediately, all outputs 0, no time_valid; normal poll after release.

Source files
------------

// File: rtl/rtc_poll_master_pkg.sv
// rtc_poll_master_pkg: shared states, register offsets, field widths and divider helpers
package rtc_poll_master_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SET,
    S_RD_MD,
    S_RD_HM,
    S_RD_MS,
    S_DIV_MS,
    S_DIV_HM,
    S_DIV_MD,
    S_CHECK
  } state_t;

  localparam logic [31:0] OFS_INIT = 32'h0;
  localparam logic [31:0] OFS_MD   = 32'h4;
  localparam logic [31:0] OFS_HM   = 32'h8;
  localparam logic [31:0] OFS_MS   = 32'hC;

  localparam int WORD_W   = 14;
  localparam int PART_W   = 7;
  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;
  localparam int DAY_W    = 5;
  localparam int MONTH_W  = 4;
  localparam int SETVAL_W = 26;

  localparam int DIV_STEPS = 7;

  // Trial subtrahend for a given step: 6400 first, halving down to 100.
  function automatic logic [WORD_W-1:0] trial_divisor(input logic [2:0] step);
    return 14'd100 << (3'(DIV_STEPS - 1) - step);
  endfunction

endpackage

// File: rtl/rtc_poll_master_dec100.sv
// dec100_split: sequential restoring divide-by-100 of a 14-bit word into quotient and remainder
module dec100_split
  import rtc_poll_master_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] value,
  output logic [PART_W-1:0] quot,
  output logic [PART_W-1:0] rem,
  output logic              done
);

  logic [WORD_W-1:0] r;
  logic [WORD_W-1:0] src;
  logic [WORD_W-1:0] dvs;
  logic [2:0]        k;
  logic [2:0]        idx;
  logic              active;
  logic              ge;

  // The first trial happens in the start cycle itself, so done lands 7 cycles after start.
  always_comb begin
    src = start ? value : r;
    idx = start ? 3'd0 : k;
    dvs = trial_divisor(idx);
    ge  = src >= dvs;
  end

  // One trial subtract per cycle; a fresh start always wins over an active run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r      <= '0;
      quot   <= '0;
      k      <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r      <= ge ? src - dvs : src;
        quot   <= {6'b0, ge};
        k      <= 3'd1;
        active <= 1'b1;
      end else if (active) begin
        r    <= ge ? src - dvs : src;
        quot <= {quot[PART_W-2:0], ge};
        k    <= k + 3'd1;
        if (k == 3'(DIV_STEPS - 1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign rem = r[PART_W-1:0];

endmodule

// File: rtl/rtc_poll_master.sv
// rtc_poll_master: polls the RTC register block, splits the decimal words and publishes a coherent time snapshot
module rtc_poll_master
  import rtc_poll_master_pkg::*;
#(
  parameter int          POLL_DIV  = 100000000,
  parameter int          MAX_RETRY = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                poll_en,
  input  logic                set_req,
  input  logic [SETVAL_W-1:0] set_value,
  output logic                set_ack,
  output logic                bus_cs,
  output logic                bus_wr,
  output logic [31:0]         bus_addr,
  output logic [31:0]         bus_wdata,
  input  logic [31:0]         bus_rdata,
  output logic [SEC_W-1:0]    sec,
  output logic [MIN_W-1:0]    min,
  output logic [HOUR_W-1:0]   hour,
  output logic [DAY_W-1:0]    day,
  output logic [MONTH_W-1:0]  month,
  output logic                time_valid,
  output logic                read_err,
  output logic                busy
);

  localparam int CNT_W   = $clog2(POLL_DIV);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                tick;
  logic                pending;
  logic [RETRY_W-1:0]  retry;
  logic [WORD_W-1:0]   md;
  logic [WORD_W-1:0]   hm;
  logic [WORD_W-1:0]   ms;
  logic [PART_W-1:0]   ms_q;
  logic [SEC_W-1:0]    ms_r;
  logic [HOUR_W-1:0]   hm_q;
  logic [PART_W-1:0]   hm_r;
  logic [MONTH_W-1:0]  md_q;
  logic [DAY_W-1:0]    md_r;
  logic                div_start;
  logic [WORD_W-1:0]   div_value;
  logic [PART_W-1:0]   div_quot;
  logic [PART_W-1:0]   div_rem;
  logic                div_done;
  logic                take;
  logic                unused_rdata;

  assign tick         = poll_en && (cnt == CNT_W'(POLL_DIV - 1));
  assign take         = (state == S_IDLE) && !set_req && (tick || pending);
  assign busy         = state != S_IDLE;
  assign unused_rdata = ^bus_rdata[31:WORD_W];

  // The divider works on whichever captured word the current divide state owns.
  always_comb begin
    div_value = state == S_DIV_MS ? ms : state == S_DIV_HM ? hm : md;
  end

  dec100_split u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .value (div_value),
    .quot  (div_quot),
    .rem   (div_rem),
    .done  (div_done)
  );

  // Free-running poll interval counter, held at zero while polling is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else cnt <= (!poll_en || tick) ? '0 : cnt + 1'b1;
  end

  // Bus sequencing, divide scheduling, tear check and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      retry      <= '0;
      bus_cs     <= 1'b0;
      bus_wr     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      set_ack    <= 1'b0;
      time_valid <= 1'b0;
      read_err   <= 1'b0;
      div_start  <= 1'b0;
      md         <= '0;
      hm         <= '0;
      ms         <= '0;
      ms_q       <= '0;
      ms_r       <= '0;
      hm_q       <= '0;
      hm_r       <= '0;
      md_q       <= '0;
      md_r       <= '0;
      sec        <= '0;
      min        <= '0;
      hour       <= '0;
      day        <= '0;
      month      <= '0;
    end else begin
      set_ack    <= 1'b0;
      time_valid <= 1'b0;
      read_err   <= 1'b0;
      div_start  <= 1'b0;
      pending    <= !poll_en ? 1'b0 : take ? 1'b0 : tick ? 1'b1 : pending;
      case (state)
        S_IDLE: begin
          if (set_req) begin
            state     <= S_SET;
            bus_cs    <= 1'b1;
            bus_wr    <= 1'b1;
            bus_addr  <= BASE_ADDR + OFS_INIT;
            bus_wdata <= {6'b0, set_value};
          end else if (tick || pending) begin
            state    <= S_RD_MD;
            bus_cs   <= 1'b1;
            bus_addr <= BASE_ADDR + OFS_MD;
          end
        end
        S_SET: begin
          state     <= S_IDLE;
          bus_cs    <= 1'b0;
          bus_wr    <= 1'b0;
          bus_addr  <= '0;
          bus_wdata <= '0;
          set_ack   <= 1'b1;
        end
        S_RD_MD: begin
          md       <= bus_rdata[WORD_W-1:0];
          bus_addr <= BASE_ADDR + OFS_HM;
          state    <= S_RD_HM;
        end
        S_RD_HM: begin
          hm       <= bus_rdata[WORD_W-1:0];
          bus_addr <= BASE_ADDR + OFS_MS;
          state    <= S_RD_MS;
        end
        S_RD_MS: begin
          ms        <= bus_rdata[WORD_W-1:0];
          bus_cs    <= 1'b0;
          bus_addr  <= '0;
          div_start <= 1'b1;
          state     <= S_DIV_MS;
        end
        S_DIV_MS: begin
          if (div_done) begin
            ms_q      <= div_quot;
            ms_r      <= div_rem[SEC_W-1:0];
            div_start <= 1'b1;
            state     <= S_DIV_HM;
          end
        end
        S_DIV_HM: begin
          if (div_done) begin
            hm_q      <= div_quot[HOUR_W-1:0];
            hm_r      <= div_rem;
            div_start <= 1'b1;
            state     <= S_DIV_MD;
          end
        end
        S_DIV_MD: begin
          if (div_done) begin
            md_q  <= div_quot[MONTH_W-1:0];
            md_r  <= div_rem[DAY_W-1:0];
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Minutes appear in both HM and MS; agreement means no rollover hit mid-read.
          if (hm_r == ms_q) begin
            sec        <= ms_r;
            min        <= ms_q[MIN_W-1:0];
            hour       <= hm_q;
            day        <= md_r;
            month      <= md_q;
            time_valid <= 1'b1;
            retry      <= '0;
            state      <= S_IDLE;
          end else if (retry < RETRY_W'(MAX_RETRY)) begin
            retry    <= retry + 1'b1;
            bus_cs   <= 1'b1;
            bus_addr <= BASE_ADDR + OFS_MD;
            state    <= S_RD_MD;
          end else begin
            read_err <= 1'b1;
            retry    <= '0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_poll_master.sv
// tb_rtc_poll_master: randomized scoreboard bench with a decimal-arithmetic reference model
module tb_rtc_poll_master;

  localparam int          POLL_DIV  = 40;
  localparam int          MAX_RETRY = 2;
  localparam logic [31:0] BASE      = 32'h0;

  typedef struct {
    bit err;
    int sec;
    int min;
    int hour;
    int day;
    int month;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        poll_en;
  logic        set_req;
  logic [25:0] set_value;
  logic        set_ack;
  logic        bus_cs;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [5:0]  sec;
  logic [5:0]  min;
  logic [4:0]  hour;
  logic [4:0]  day;
  logic [3:0]  month;
  logic        time_valid;
  logic        read_err;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          md_a[512];
  int          hm_a[512];
  int          ms_a[512];
  logic [17:0] hi_a[512];
  int          pass_wr = 0;
  int          pass_rd = 0;
  exp_t        sb[$];
  exp_t        last;
  exp_t        mx;
  logic [31:0] wq[$];
  logic [31:0] wx;

  rtc_poll_master #(
    .POLL_DIV  (POLL_DIV),
    .MAX_RETRY (MAX_RETRY),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .poll_en    (poll_en),
    .set_req    (set_req),
    .set_value  (set_value),
    .set_ack    (set_ack),
    .bus_cs     (bus_cs),
    .bus_wr     (bus_wr),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .day        (day),
    .month      (month),
    .time_valid (time_valid),
    .read_err   (read_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Peripheral model: each read pass serves one stored triple, upper bits are noise.
  always_comb begin
    bus_rdata = '0;
    if (pass_rd < pass_wr)
      bus_rdata = bus_addr == BASE + 32'h4 ? {hi_a[pass_rd], 14'(md_a[pass_rd])} :
                  bus_addr == BASE + 32'h8 ? {hi_a[pass_rd], 14'(hm_a[pass_rd])} :
                  bus_addr == BASE + 32'hC ? {hi_a[pass_rd], 14'(ms_a[pass_rd])} : 32'h0;
  end

  always @(posedge clk) if (bus_cs && !bus_wr && bus_addr == BASE + 32'hC) pass_rd <= pass_rd + 1;

  task automatic add_pass(input int md, input int hm, input int ms);
    md_a[pass_wr] = md;
    hm_a[pass_wr] = hm;
    ms_a[pass_wr] = ms;
    hi_a[pass_wr] = 18'($urandom);
    pass_wr++;
  endtask

  task automatic gen_pass(input bit torn);
    int h, m, m2, s;
    h  = $urandom_range(0, 99);
    m  = $urandom_range(0, 99);
    s  = $urandom_range(0, 99);
    m2 = torn ? (m + $urandom_range(1, 99)) % 100 : m;
    add_pass($urandom_range(0, 9999), h * 100 + m, m2 * 100 + s);
  endtask

  // Reference: the first of up to MAX_RETRY+1 passes whose two minute copies agree wins.
  task automatic expect_poll(input int first, input int n);
    exp_t e;
    e = last;
    e.err = 1'b1;
    for (int a = 0; a < n && a <= MAX_RETRY; a++) begin
      int p;
      p = first + a;
      if (e.err && hm_a[p] % 100 == ms_a[p] / 100) begin
        e.err   = 1'b0;
        e.sec   = (ms_a[p] % 100) % 64;
        e.min   = (ms_a[p] / 100) % 64;
        e.hour  = (hm_a[p] / 100) % 32;
        e.day   = (md_a[p] % 100) % 32;
        e.month = (md_a[p] / 100) % 16;
      end
    end
    if (!e.err) last = e;
    sb.push_back(e);
  endtask

  task automatic rand_poll();
    int t, first;
    first = pass_wr;
    t = $urandom_range(0, 3);
    for (int i = 0; i < t; i++) gen_pass(1'b1);
    if (t <= MAX_RETRY) gen_pass(1'b0);
    expect_poll(first, pass_wr - first);
  endtask

  task automatic wait_read(input string name, output int t);
    int n;
    n = 0;
    while (!(bus_cs && !bus_wr && bus_addr == BASE + 32'h4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 200, 1);
    t = cyc;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  // Monitor: idle-bus hygiene, write contents, and result pulses against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (!bus_cs) chk("idle_bus_zero", bus_wr || bus_addr != 0 || bus_wdata != 0, 0);
      if (bus_cs && bus_wr) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wx = wq.pop_front();
          chk("write_addr", bus_addr, BASE);
          chk("write_data", bus_wdata, wx);
        end
      end
      if (time_valid || read_err) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          mx = sb.pop_front();
          chk("both_pulses", time_valid && read_err, 0);
          chk("result_is_err", read_err, mx.err);
          chk("sec", sec, mx.sec);
          chk("min", min, mx.min);
          chk("hour", hour, mx.hour);
          chk("day", day, mx.day);
          chk("month", month, mx.month);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int t0, first, n, c0, wcyc, rcyc;
    reset = 1'b1;
    poll_en = 1'b0;
    set_req = 1'b0;
    set_value = '0;
    last = '{err: 1'b0, sec: 0, min: 0, hour: 0, day: 0, month: 0};
    repeat (3) @(negedge clk);
    chk("rst_bus_cs", bus_cs, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_time", {sec, min, hour, day, month}, 0);
    chk("rst_pulses", {set_ack, time_valid, read_err, busy}, 0);
    reset = 1'b0;

    // Initial-value write.
    set_value = 26'h123456;
    set_req = 1'b1;
    wq.push_back(32'h00123456);
    n = 0;
    while (!bus_cs && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("set_cs", bus_cs, 1);
    chk("set_wr", bus_wr, 1);
    chk("set_addr", bus_addr, 32'h0);
    chk("set_wdata", bus_wdata, 32'h00123456);
    @(negedge clk);
    chk("set_ack", set_ack, 1);
    chk("set_single_cycle", bus_cs, 0);
    set_req = 1'b0;
    @(negedge clk);
    chk("set_busy_after", busy, 0);
    chk("set_ack_pulse", set_ack, 0);

    // Poll decode and latency.
    first = pass_wr;
    add_pass(1231, 2359, 5958);
    expect_poll(first, 1);
    poll_en = 1'b1;
    wait_read("decode_read_start", t0);
    poll_en = 1'b0;
    n = 0;
    while (!time_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("decode_latency", cyc - t0, 28);
    chk("decode_month", month, 12);
    chk("decode_day", day, 31);
    chk("decode_hour", hour, 23);
    chk("decode_min", min, 59);
    chk("decode_sec", sec, 58);
    wait_done("decode_done", 100);

    // Tear, then a clean re-read.
    first = pass_wr;
    add_pass(101, 2359, 0);
    add_pass(101, 0, 0);
    expect_poll(first, 2);
    poll_en = 1'b1;
    wait_read("recover_read_start", t0);
    poll_en = 1'b0;
    wait_done("recover_done", 200);
    chk("recover_passes", pass_rd - first, 2);
    chk("recover_hms", {hour, min, sec}, 0);

    // Persistent tear exhausts the retries.
    first = pass_wr;
    for (int i = 0; i < 3; i++) add_pass(1231, 1005, 600);
    expect_poll(first, 3);
    poll_en = 1'b1;
    wait_read("exhaust_read_start", t0);
    poll_en = 1'b0;
    wait_done("exhaust_done", 300);
    chk("exhaust_passes", pass_rd - first, 3);
    chk("exhaust_hold_day", day, 1);
    chk("exhaust_hold_month", month, 1);

    // set_req and tick together; a long poll sees one tick pend and a second dropped.
    first = pass_wr;
    for (int i = 0; i < 3; i++) gen_pass(1'b1);
    expect_poll(first, 3);
    gen_pass(1'b0);
    expect_poll(first + 3, 1);
    @(negedge clk);
    poll_en = 1'b1;
    repeat (39) @(posedge clk);
    @(negedge clk);
    set_value = 26'($urandom);
    wq.push_back({6'b0, set_value});
    set_req = 1'b1;
    c0 = cyc;
    wcyc = -1;
    rcyc = -1;
    for (int k = 1; k <= 118; k++) begin
      @(negedge clk);
      if (set_ack) set_req = 1'b0;
      if (bus_cs && bus_wr && wcyc < 0) wcyc = cyc - c0;
      if (bus_cs && !bus_wr && bus_addr == BASE + 32'h4 && rcyc < 0) rcyc = cyc - c0;
    end
    poll_en = 1'b0;
    wait_done("arb_done", 300);
    chk("arb_set_cycle", wcyc, 1);
    chk("arb_poll_cycle", rcyc, 3);
    chk("arb_passes", pass_rd - first, 4);

    // Reset in the middle of the hour/minute divide.
    gen_pass(1'b0);
    poll_en = 1'b1;
    wait_read("rstmid_read_start", t0);
    poll_en = 1'b0;
    while (cyc - t0 < 13) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid_cs", bus_cs, 0);
    chk("rstmid_time", {sec, min, hour, day, month}, 0);
    chk("rstmid_pulses", {time_valid, read_err, busy, set_ack}, 0);
    last = '{err: 1'b0, sec: 0, min: 0, hour: 0, day: 0, month: 0};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    first = pass_wr;
    gen_pass(1'b0);
    expect_poll(first, 1);
    poll_en = 1'b1;
    wait_read("rstmid_repoll_start", t0);
    poll_en = 1'b0;
    wait_done("rstmid_repoll_done", 200);

    // Randomized polls with interleaved set requests.
    for (int i = 0; i < 14; i++) rand_poll();
    poll_en = 1'b1;
    fork
      begin
        repeat (4) begin
          repeat ($urandom_range(20, 80)) @(negedge clk);
          set_value = 26'($urandom);
          wq.push_back({6'b0, set_value});
          set_req = 1'b1;
          n = 0;
          while (!set_ack && n < 300) begin
            @(negedge clk);
            n++;
          end
          chk("rand_set_ack", set_ack, 1);
          set_req = 1'b0;
        end
      end
      begin
        int m;
        m = 0;
        while (pass_rd < pass_wr && m < 6000) begin
          @(negedge clk);
          m++;
        end
        poll_en = 1'b0;
        chk("rand_passes_consumed", pass_rd, pass_wr);
      end
    join
    wait_done("rand_done", 400);
    chk("rand_writes_drained", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
